key_debounce: RTL and testbench

Per-key debouncer and edge detector sitting directly upstream of the LED state/speed controller. Raw, bouncing, active-low push-button inputs are synchronised to `clk`, filtered with a stable-time counter, and presented as clean active-low levels. The block also emits one-cycle press and release pulses, so the controller sees exactly one event per physical press.

---
 rtl/key_debounce_pkg.sv | 19 +
 rtl/key_filter_ch.sv | 144 ++++++++++++++
 rtl/key_debounce.sv | 38 +++
 tb/tb_key_debounce.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the key debouncer: channel FSM states,
// default filter lengths and a small helper for sizing the shared counter.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FILT,
        HELD,
        REL_FILT
    } key_state_e;

    localparam int KEY_DEBOUNCE_DEFAULT = 1_000_000;
    localparam int KEY_LONG_DEFAULT     = 50_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One debounced key: 2-flop synchroniser, stable-time counter and 4-state FSM.
// Long-press detection in HELD is built only with KEY_DEBOUNCE_LONG_PRESS_EN.
module key_filter_ch
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = KEY_DEBOUNCE_DEFAULT,
    parameter int LONG_PRESS_CYCLES = KEY_LONG_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic key_n,
    output logic press,
    output logic key_release,
    output logic long_press
);

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif
    localparam int CNT_MAX = LONG_EN ? max_int(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)
                                     : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_CYCLES);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_PRESS_CYCLES);
`endif

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_n_q, key_n_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    logic             long_q, long_d;
`endif

    always_comb begin
        sync1_d = key_raw_n;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        key_n_d = key_n_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        long_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!sync2_q) begin
                    state_d = PRESS_FILT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_FILT: begin
                if (sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_CNT) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    key_n_d = 1'b0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (sync2_q) begin
                    state_d = REL_FILT;
                    cnt_d   = CNT_ONE;
                end
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
                // Saturating at the threshold makes the pulse one-shot per press.
                else if (cnt_q != LONG_SAT) begin
                    cnt_d  = cnt_q + CNT_ONE;
                    long_d = (cnt_q == LONG_LAST);
                end
`endif
            end
            REL_FILT: begin
                if (!sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    key_n_d = 1'b1;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            key_n_q <= 1'b1;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
            long_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_n_q <= key_n_d;
            press_q <= press_d;
            rel_q   <= rel_d;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
            long_q  <= long_d;
`endif
        end
    end

    assign key_n       = key_n_q;
    assign press       = press_q;
    assign key_release = rel_q;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    assign long_press  = long_q;
`else
    assign long_press  = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: NUM_KEYS independent key_filter_ch channels. The release
// pulse port is key_release because `release` is a reserved word in SystemVerilog.
// Long-press output is live only with KEY_DEBOUNCE_LONG_PRESS_EN defined.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES   = KEY_DEBOUNCE_DEFAULT,
    parameter int LONG_PRESS_CYCLES = KEY_LONG_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_raw_n,
    output logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] long_press
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
            key_filter_ch #(
                .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
                .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .key_raw_n  (key_raw_n[gi]),
                .key_n      (key_n[gi]),
                .press      (press[gi]),
                .key_release(key_release[gi]),
                .long_press (long_press[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed timing scenarios plus random
// bouncing stimulus against a run-length reference model of the key filter.
module tb_key_debounce;

    localparam int NK = 2;
    localparam int DB = 8;
    localparam int LP = 40;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_raw_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] long_press;

    key_debounce #(
        .NUM_KEYS         (NK),
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_raw_n  (key_raw_n),
        .key_n      (key_n),
        .press      (press),
        .key_release(key_release),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    // Reference model: the filter sees each raw sample two edges late and accepts
    // a new level after DB+1 consecutive samples that disagree with the current one.
    logic [NK-1:0] raw_hist[$];
    logic [NK-1:0] m_key_n, m_press, m_rel, m_long;
    int            m_run[NK];
    int            m_age[NK];

    function automatic void model_edge(input logic rst_in, input logic [NK-1:0] raw_in);
        logic [NK-1:0] seen;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        if (!rst_in) begin
            m_key_n = '1;
            for (int k = 0; k < NK; k++) begin
                m_run[k] = 0;
                m_age[k] = 0;
            end
            raw_hist = {};
            raw_hist.push_back('1);
            raw_hist.push_back('1);
            return;
        end
        seen = raw_hist.pop_front();
        raw_hist.push_back(raw_in);
        for (int k = 0; k < NK; k++) begin
            if (seen[k] != m_key_n[k]) begin
                m_run[k]++;
                if (m_run[k] == DB + 1) begin
                    m_key_n[k] = seen[k];
                    m_run[k]   = 0;
                    m_age[k]   = 0;
                    if (seen[k] == 1'b0) m_press[k] = 1'b1;
                    else                 m_rel[k]   = 1'b1;
                end
            end else begin
                if (m_key_n[k] == 1'b0) begin
                    if (m_run[k] > 0) m_age[k] = 0;
                    else begin
                        m_age[k]++;
                        if (m_age[k] == LP && LONG_EN) m_long[k] = 1'b1;
                    end
                end
                m_run[k] = 0;
            end
        end
    endfunction

    int edge_no = 0;
    int e0      = 0;
    int press_edge[NK], rel_edge[NK], long_edge[NK];
    int press_cnt[NK], rel_cnt[NK], long_cnt[NK];
    int key1_low_cnt;

    task automatic clear_events();
        e0 = edge_no + 1;
        key1_low_cnt = 0;
        for (int k = 0; k < NK; k++) begin
            press_edge[k] = -1; rel_edge[k] = -1; long_edge[k] = -1;
            press_cnt[k]  = 0;  rel_cnt[k]  = 0;  long_cnt[k]  = 0;
        end
    endtask

    task automatic tick();
        logic          r;
        logic [NK-1:0] raw;
        r   = rst_n;
        raw = key_raw_n;
        @(posedge clk);
        edge_no++;
        model_edge(r, raw);
        #1;
        check("key_n", key_n, m_key_n);
        check("press", press, m_press);
        check("release", key_release, m_rel);
        check("long_press", long_press, m_long);
        if (!key_n[1]) key1_low_cnt++;
        for (int k = 0; k < NK; k++) begin
            if (press[k]) begin
                press_cnt[k]++;
                if (press_edge[k] < 0) press_edge[k] = edge_no - e0;
                $display("edge %0d key %0d press", edge_no - e0, k);
            end
            if (key_release[k]) begin
                rel_cnt[k]++;
                if (rel_edge[k] < 0) rel_edge[k] = edge_no - e0;
                $display("edge %0d key %0d release", edge_no - e0, k);
            end
            if (long_press[k]) begin
                long_cnt[k]++;
                if (long_edge[k] < 0) long_edge[k] = edge_no - e0;
                $display("edge %0d key %0d long_press", edge_no - e0, k);
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        key_raw_n = '1;
        tick();
        tick();
        check("reset_key_n", key_n, 2'b11);
        check("reset_pulses", {press, key_release, long_press}, 6'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    int hold[NK];

    initial begin
        rst_n     = 1'b0;
        key_raw_n = '1;

        // Clean press then release of key 0 at edge 100.
        do_reset();
        clear_events();
        for (int e = 0; e < 130; e++) begin
            key_raw_n[0] = (e < 100) ? 1'b0 : 1'b1;
            tick();
        end
        check("clean_press_edge", press_edge[0], 10);
        check("clean_press_count", press_cnt[0], 1);
        check("key1_never_low", key1_low_cnt, 0);
        check("release_edge", rel_edge[0], 110);
        check("release_count", rel_cnt[0], 1);
        check("long_press_count_short", long_cnt[0], LONG_EN ? 1 : 0);

        // Long hold through edge 200.
        do_reset();
        clear_events();
        for (int e = 0; e <= 200; e++) begin
            key_raw_n[0] = 1'b0;
            tick();
        end
        check("long_press_count", long_cnt[0], LONG_EN ? 1 : 0);
        check("long_press_edge", long_edge[0], LONG_EN ? 50 : -1);
        key_raw_n = '1;
        for (int i = 0; i < 15; i++) tick();

        // Bounce rejection, then a final fall that is held.
        do_reset();
        clear_events();
        for (int e = 0; e < 30; e++) begin
            key_raw_n[0] = (e < 5 || (e >= 6 && e < 9)) ? 1'b0 : 1'b1;
            tick();
        end
        check("bounce_no_press", press_cnt[0], 0);
        clear_events();
        for (int e = 0; e < 30; e++) begin
            key_raw_n[0] = (e == 5) ? 1'b1 : 1'b0;
            tick();
        end
        check("bounce_then_hold_press_edge", press_edge[0], 16);
        key_raw_n = '1;
        for (int i = 0; i < 15; i++) tick();

        // Both keys fall on the same edge.
        do_reset();
        clear_events();
        for (int e = 0; e < 20; e++) begin
            key_raw_n = 2'b00;
            tick();
        end
        check("simul_press_edge0", press_edge[0], 10);
        check("simul_press_edge1", press_edge[1], 10);
        key_raw_n = '1;
        for (int i = 0; i < 15; i++) tick();

        // Reset at edge 20 while held; fresh press 10 edges after reset lifts.
        do_reset();
        clear_events();
        for (int e = 0; e < 45; e++) begin
            key_raw_n[0] = 1'b0;
            rst_n        = (e == 20) ? 1'b0 : 1'b1;
            tick();
            if (e == 20) begin
                check("midreset_key_n", key_n, 2'b11);
                check("midreset_pulses", {press, key_release}, 4'd0);
            end
        end
        check("midreset_no_release", rel_cnt[0], 0);
        check("midreset_press_count", press_cnt[0], 2);
        check("midreset_first_press", press_edge[0], 10);
        key_raw_n = '1;
        for (int i = 0; i < 15; i++) tick();

        // Random bouncing stimulus with occasional resets.
        do_reset();
        clear_events();
        for (int k = 0; k < NK; k++) hold[k] = 0;
        for (int e = 0; e < 4000; e++) begin
            for (int k = 0; k < NK; k++) begin
                if (hold[k] == 0) begin
                    key_raw_n[k] = 1'($urandom_range(0, 1));
                    hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60)
                                                           : $urandom_range(1, 14);
                end
                hold[k]--;
            end
            rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
